// File: rtl/mi_loader.sv
// mi_loader: fills instruction memory from a byte stream, verifies an XOR checksum, holds the CPU in reset meanwhile
module mi_loader #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int BASE   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              hold,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHK, DONE, ERR} state_t;
  localparam logic [15:0] MAX_CNT = 16'(DEPTH - BASE);
  state_t      state_q;
  logic [15:0] rem_q;
  logic [7:0]  chk_q;
  logic [1:0]  idx_q;
  logic [23:0] word_q;
  logic        xfer;
  logic [15:0] cnt;
  assign rx_ready = state_q inside {HDR_HI, HDR_LO, DATA, CHK};
  assign xfer     = rx_valid & rx_ready;
  assign cnt      = {rem_q[15:8], rx_data};
  // load sequencer: header parse, word assembly, memory write, checksum verdict
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      chk_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      hold    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: if (start) begin
          state_q <= HDR_HI;
          hold    <= 1'b1;
          done    <= 1'b0;
          err     <= 1'b0;
          chk_q   <= '0;
        end
        HDR_HI: if (xfer) begin
          rem_q[15:8] <= rx_data;
          chk_q       <= chk_q ^ rx_data;
          state_q     <= HDR_LO;
        end
        HDR_LO: if (xfer) begin
          rem_q[7:0] <= rx_data;
          chk_q      <= chk_q ^ rx_data;
          if (cnt > MAX_CNT) begin
            state_q <= ERR;
            err     <= 1'b1;
          end else if (cnt == 16'd0) begin
            state_q <= CHK;
          end else begin
            state_q <= DATA;
            waddr   <= ADDR_W'(BASE);
            idx_q   <= '0;
          end
        end
        DATA: if (xfer) begin
          word_q <= {word_q[15:0], rx_data};
          chk_q  <= chk_q ^ rx_data;
          idx_q  <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_q <= WRITE;
            we      <= 1'b1;
            wdata   <= {word_q, rx_data};
          end
        end
        WRITE: begin
          we    <= 1'b0;
          rem_q <= rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_q <= CHK;
          end else begin
            state_q <= DATA;
            waddr   <= waddr + ADDR_W'(1);
            idx_q   <= '0;
          end
        end
        CHK: if (xfer) begin
          if (rx_data == chk_q) begin
            state_q <= DONE;
            done    <= 1'b1;
            hold    <= 1'b0;
          end else begin
            state_q <= ERR;
            err     <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule
